// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED driver. Each channel has its own
// counter, half-period and mode (OFF, ON, BLINK, ONE_SHOT). A valid/ready
// config port reprograms one channel per accepted write. Out of reset every
// channel blinks, with channel k using (g_DEFAULT_HALF << k) as half-period.
module led_blink_multi #(
    parameter  int g_CHANNELS     = 4,
    parameter  int g_CNT_WIDTH    = 24,
    parameter  int g_DEFAULT_HALF = 25,
    localparam int c_SEL_W        = (g_CHANNELS > 1) ? $clog2(g_CHANNELS) : 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Cfg_Valid,
    output logic                   o_Cfg_Ready,
    input  logic [c_SEL_W-1:0]     i_Cfg_Chan,
    input  logic [1:0]             i_Cfg_Mode,
    input  logic [g_CNT_WIDTH-1:0] i_Cfg_Half,
    output logic [g_CHANNELS-1:0]  o_LED,
    output logic [g_CHANNELS-1:0]  o_Wrap
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    mode_t                  r_mode [g_CHANNELS];
    logic [g_CNT_WIDTH-1:0] r_half [g_CHANNELS];
    logic [g_CNT_WIDTH-1:0] r_cnt  [g_CHANNELS];
    logic [g_CNT_WIDTH-1:0] w_last [g_CHANNELS];
    logic [g_CHANNELS-1:0]  r_led;
    logic [g_CHANNELS-1:0]  r_wrap;
    logic [g_CHANNELS-1:0]  w_sel;
    logic                   r_ready;
    logic                   w_accept;

    // Reset half-period of channel k; bits shifted past the counter width drop.
    function automatic logic [g_CNT_WIDTH-1:0] default_half(input int k);
        logic [g_CNT_WIDTH-1:0] v;
        v = g_CNT_WIDTH'(g_DEFAULT_HALF);
        return v << k;
    endfunction

    // Accept decode, per-channel write select and terminal count (H-1, H>=1).
    always_comb begin
        w_accept = i_Cfg_Valid && r_ready;
        w_sel    = '0;
        for (int k = 0; k < g_CHANNELS; k++) begin
            w_sel[k]  = w_accept && (int'(i_Cfg_Chan) == k);
            w_last[k] = (r_half[k] == '0) ? '0 : r_half[k] - g_CNT_WIDTH'(1);
        end
    end

    // Ready is low for exactly the cycle after an accept; low through reset.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_ready <= 1'b0;
        else       r_ready <= !w_accept;
    end

    // Per-channel state: a config write wins over that channel's counter action.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int k = 0; k < g_CHANNELS; k++) begin
                r_mode[k] <= MODE_BLINK;
                r_half[k] <= default_half(k);
                r_cnt[k]  <= '0;
            end
            r_led  <= '0;
            r_wrap <= '0;
        end else begin
            for (int k = 0; k < g_CHANNELS; k++) begin
                if (w_sel[k]) begin
                    r_mode[k] <= mode_t'(i_Cfg_Mode);
                    r_half[k] <= i_Cfg_Half;
                    r_cnt[k]  <= '0;
                    r_wrap[k] <= 1'b0;
                    // ON and ONE_SHOT both start lit; they share mode bit 0.
                    r_led[k]  <= i_Cfg_Mode[0];
                end else begin
                    case (r_mode[k])
                        MODE_BLINK: begin
                            if (r_cnt[k] == w_last[k]) begin
                                r_cnt[k]  <= '0;
                                r_led[k]  <= !r_led[k];
                                r_wrap[k] <= 1'b1;
                            end else begin
                                r_cnt[k]  <= r_cnt[k] + g_CNT_WIDTH'(1);
                                r_wrap[k] <= 1'b0;
                            end
                        end
                        MODE_ONESHOT: begin
                            if (r_cnt[k] == w_last[k]) begin
                                r_cnt[k]  <= '0;
                                r_led[k]  <= 1'b0;
                                r_mode[k] <= MODE_OFF;
                                r_wrap[k] <= 1'b1;
                            end else begin
                                r_cnt[k]  <= r_cnt[k] + g_CNT_WIDTH'(1);
                                r_wrap[k] <= 1'b0;
                            end
                        end
                        default: begin
                            // OFF / ON: LED level held, counter parked at zero.
                            r_cnt[k]  <= '0;
                            r_wrap[k] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_Cfg_Ready = r_ready;
    assign o_LED       = r_led;
    assign o_Wrap      = r_wrap;

endmodule

// File: tb/tb_led_blink_multi.sv
// Testbench for led_blink_multi: a closed-form timing model of each channel
// (start edge, half-period, starting level) feeds a scoreboard queue that is
// compared every cycle, plus a config-write table and a few directed sequences.
module tb_led_blink_multi;

    localparam int NCH = 5;
    localparam int CW  = 24;
    localparam int DH  = 5;
    localparam int SW  = 3;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic           vld  = 1'b0;
    logic [SW-1:0]  chan = '0;
    logic [1:0]     mode = '0;
    logic [CW-1:0]  half = '0;
    logic           ready;
    logic [NCH-1:0] led;
    logic [NCH-1:0] wrap;

    always #5 clk = ~clk;

    led_blink_multi #(
        .g_CHANNELS    (NCH),
        .g_CNT_WIDTH   (CW),
        .g_DEFAULT_HALF(DH)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Cfg_Valid(vld),
        .o_Cfg_Ready(ready),
        .i_Cfg_Chan (chan),
        .i_Cfg_Mode (mode),
        .i_Cfg_Half (half),
        .o_LED      (led),
        .o_Wrap     (wrap)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: edges counted from reset release; per channel the edge
    // at which its current behaviour started and the level it started with.
    int m_t;
    bit m_ready;
    int m_mode [NCH];
    int m_h    [NCH];
    int m_t0   [NCH];
    bit m_led0 [NCH];

    typedef logic [2*NCH:0] obs_t;
    obs_t sb[$];

    task automatic model_reset();
        m_t     = 0;
        m_ready = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = 2;
            m_h[k]    = ((DH << k) & ((1 << CW) - 1));
            if (m_h[k] == 0) m_h[k] = 1;
            m_t0[k]   = 0;
            m_led0[k] = 1'b0;
        end
    endtask

    task automatic model_outputs(output logic [NCH-1:0] el, output logic [NCH-1:0] ew);
        int n;
        el = '0;
        ew = '0;
        for (int k = 0; k < NCH; k++) begin
            n = m_t - m_t0[k];
            case (m_mode[k])
                1: el[k] = 1'b1;
                2: begin
                    el[k] = m_led0[k] ^ (((n / m_h[k]) % 2) == 1);
                    ew[k] = (n > 0) && ((n % m_h[k]) == 0);
                end
                3: begin
                    el[k] = (n < m_h[k]);
                    ew[k] = (n == m_h[k]);
                end
                default: el[k] = 1'b0;
            endcase
        end
    endtask

    // One clock: predict this edge, push, then compare #1 after the edge.
    task automatic step();
        logic           accept;
        logic [NCH-1:0] el, ew;
        obs_t           exp_o;
        m_t++;
        accept = vld && m_ready;
        if (accept && (int'(chan) < NCH)) begin
            m_mode[chan] = int'(mode);
            m_h[chan]    = (half == '0) ? 1 : int'(half);
            m_t0[chan]   = m_t;
            m_led0[chan] = mode[0];
        end
        m_ready = !accept;
        model_outputs(el, ew);
        sb.push_back({m_ready, ew, el});
        @(posedge clk);
        #1;
        exp_o = sb.pop_front();
        check($sformatf("cycle t=%0d {rdy,wrap,led}", m_t), 64'({ready, wrap, led}), 64'(exp_o));
    endtask

    task automatic write_cfg(input int c, input logic [1:0] md, input int h);
        chan = SW'(c);
        mode = md;
        half = CW'(h);
        vld  = 1'b1;
        step();
        vld  = 1'b0;
    endtask

    typedef struct {
        int         gap;
        int         chan;
        logic [1:0] mode;
        int         half;
        logic       exp_led;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         hi, wr, fall_ok;
        logic       prev;
        logic [3:0] pat;

        tbl[0] = '{gap: 6,  chan: 2, mode: 2'b01, half: 0, exp_led: 1'b1};
        tbl[1] = '{gap: 6,  chan: 2, mode: 2'b00, half: 0, exp_led: 1'b0};
        tbl[2] = '{gap: 8,  chan: 1, mode: 2'b11, half: 3, exp_led: 1'b1};
        tbl[3] = '{gap: 8,  chan: 0, mode: 2'b10, half: 0, exp_led: 1'b0};
        tbl[4] = '{gap: 30, chan: 3, mode: 2'b10, half: 7, exp_led: 1'b0};
        tbl[5] = '{gap: 6,  chan: 4, mode: 2'b11, half: 2, exp_led: 1'b1};

        model_reset();
        #1;
        check("reset {rdy,wrap,led}", 64'({ready, wrap, led}), 64'(0));
        repeat (2) @(posedge clk);
        #5;
        rst = 1'b0;

        // Default multi-rate blink long enough to see channel 4 (half 80) toggle.
        repeat (90) step();

        // Config writes from the table; target LED checked right after accept.
        for (int i = 0; i < 6; i++) begin
            write_cfg(tbl[i].chan, tbl[i].mode, tbl[i].half);
            check($sformatf("vec%0d led[%0d]", i, tbl[i].chan), 64'(led[tbl[i].chan]), 64'(tbl[i].exp_led));
            repeat (tbl[i].gap) step();
        end

        // One-shot of 3 cycles on channel 1: high count, one wrap on the fall.
        write_cfg(1, 2'b11, 3);
        hi      = led[1] ? 1 : 0;
        wr      = 0;
        fall_ok = 0;
        prev    = led[1];
        repeat (6) begin
            step();
            if (led[1]) hi++;
            if (wrap[1]) begin
                wr++;
                if (prev && !led[1]) fall_ok++;
            end
            prev = led[1];
        end
        check("oneshot high cycles", 64'(hi), 64'(3));
        check("oneshot wrap pulses", 64'(wr), 64'(1));
        check("oneshot wrap on fall", 64'(fall_ok), 64'(1));

        // Invalid channel with valid held for 4 cycles: ready alternates.
        chan = SW'(5);
        mode = 2'b01;
        half = CW'(9);
        vld  = 1'b1;
        pat  = '0;
        for (int i = 0; i < 4; i++) begin
            pat = {pat[2:0], ready};
            step();
        end
        vld = 1'b0;
        check("invalid chan ready pattern", 64'(pat), 64'(4'b1010));
        repeat (3) step();

        // Asynchronous reset in the middle of a long one-shot.
        write_cfg(1, 2'b11, 100);
        repeat (20) step();
        check("mid-shot led[1]", 64'(led[1]), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        check("async reset no edge", 64'({ready, wrap, led}), 64'(0));
        @(posedge clk);
        #1;
        check("reset held", 64'({ready, wrap, led}), 64'(0));
        #3;
        rst = 1'b0;
        model_reset();
        repeat (45) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
